// File: rtl/div_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
// The pipeline side drives the decode/operands; the divider returns HI/LO and its status.
interface div_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             annul;
  logic             hold;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             ready;
  logic             busy;
  logic             stall_req;

  modport master (
    output start, signed_div, opa, opb, annul, hold,
    input  result_lo, result_hi, ready, busy, stall_req
  );

  modport slave (
    input  start, signed_div, opa, opb, annul, hold,
    output result_lo, result_hi, ready, busy, stall_req
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, quotient on LO, remainder on HI.
// Optional build macro DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             qneg_q, rneg_q;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  logic [WIDTH-1:0] abs_a, abs_b;
  logic             accept, early;

  assign abs_a  = cond_neg(bus.opa, bus.signed_div & bus.opa[WIDTH-1]);
  assign abs_b  = cond_neg(bus.opb, bus.signed_div & bus.opb[WIDTH-1]);
  assign accept = bus.start & ~bus.annul;

`ifdef DIV_EARLY_OUT_EN
  assign early = (abs_a < abs_b);
`else
  assign early = 1'b0;
`endif

  // One restoring step: bring in the next dividend bit, keep the difference if it did not borrow.
  logic [WIDTH:0]   shifted, diff;
  logic             take;
  logic [WIDTH-1:0] rem_d, quo_d;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign take    = ~diff[WIDTH];
  assign rem_d   = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], take};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q <= '0;
            if (bus.opb == '0) begin
              lo_q    <= '1;
              hi_q    <= bus.opa;
              state_q <= DONE;
            end else if (early) begin
              lo_q    <= '0;
              hi_q    <= bus.opa;
              state_q <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.annul) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              lo_q    <= cond_neg(quo_d, qneg_q);
              hi_q    <= cond_neg(rem_d, rneg_q);
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.annul || !bus.hold) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Iteration datapath carries no reset; it is always reloaded when an operation is accepted.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept) begin
      rem_q  <= '0;
      quo_q  <= abs_a;
      dvs_q  <= abs_b;
      qneg_q <= bus.signed_div & (bus.opa[WIDTH-1] ^ bus.opb[WIDTH-1]);
      rneg_q <= bus.signed_div & bus.opa[WIDTH-1];
    end else if (state_q == CALC) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
    end
  end

  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.ready     = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  // Gated by reset so the hazard unit sees no stall while the divider is held in reset.
  assign bus.stall_req = rst & (((state_q == IDLE) & accept) | (state_q == CALC));
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table for results/latency plus hold, back-to-back, annul and reset sequences.
module tb_div_unit;
  localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) dif ();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(dif));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         sd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] absu(input logic [W-1:0] v, input logic sd);
    return (sd && v[W-1]) ? (~v + 32'd1) : v;
  endfunction

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sd);
    if (b == '0) return 1;
    if (EARLY && (absu(a, sd) < absu(b, sd))) return 1;
    return W + 1;
  endfunction

  // Called just after a rising edge; the start is sampled at the next edge.
  task automatic apply(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b);
    dif.start      = 1'b1;
    dif.signed_div = sd;
    dif.opa        = a;
    dif.opb        = b;
  endtask

  // Returns at the falling edge of the first ready cycle; sb counts stall/busy pattern errors.
  task automatic wait_done(output int lat, output logic [W-1:0] lo, output logic [W-1:0] hi,
                           output int sb);
    lat = -1; lo = '0; hi = '0; sb = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.stall_req !== !dif.ready) sb++;
      if (dif.busy !== (c != 0)) sb++;
      if (dif.ready === 1'b1) begin
        lat = c;
        lo  = dif.result_lo;
        hi  = dif.result_hi;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  int           lat, sb, rdy_cnt;
  logic [W-1:0] lo, hi;

  initial begin
    vt[0]  = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2};
    vt[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
    vt[2]  = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
    vt[3]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
    vt[4]  = '{1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5};
    vt[5]  = '{1'b0, 32'd3,         32'd10,        32'd0,         32'd3};
    vt[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};
    vt[7]  = '{1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF};
    vt[8]  = '{1'b0, 32'hFFFFFFFF,  32'd10,        32'h19999999,  32'd5};
    vt[9]  = '{1'b1, 32'hFFFFFFFB,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFFB};
    vt[10] = '{1'b1, 32'd2,         32'hFFFFFFF9,  32'd0,         32'd2};
    vt[11] = '{1'b1, 32'hFFFFFFFE,  32'd7,         32'd0,         32'hFFFFFFFE};
    vt[12] = '{1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000};
    vt[13] = '{1'b0, 32'd9,         32'd3,         32'd3,         32'd0};

    rst = 1'b0;
    dif.start = 1'b0; dif.signed_div = 1'b0; dif.opa = '0; dif.opb = '0;
    dif.annul = 1'b0; dif.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_lo",    dif.result_lo, '0);
    chk("reset_hi",    dif.result_hi, '0);
    chk("reset_ready", 32'(dif.ready), 32'd0);
    chk("reset_busy",  32'(dif.busy),  32'd0);
    chk("reset_stall", 32'(dif.stall_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      apply(vt[i].sd, vt[i].a, vt[i].b);
      wait_done(lat, lo, hi, sb);
      chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
      chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(exp_lat(vt[i].a, vt[i].b, vt[i].sd)));
      chk($sformatf("v%0d_stallbusy", i), 32'(sb), 32'd0);
      @(posedge clk); #1;
      dif.start = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), {30'd0, dif.busy, dif.ready}, 32'd0);
      @(posedge clk); #1;
    end

    // DONE held for three extra cycles by hold.
    dif.hold = 1'b1;
    apply(1'b0, 32'd9, 32'd3);
    wait_done(lat, lo, hi, sb);
    chk("hold_lo0", lo, 32'd3);
    chk("hold_lat", 32'(lat), 32'(W + 1));
    dif.start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      if (i == 3) dif.hold = 1'b0;
      @(negedge clk);
      chk($sformatf("hold_ready%0d", i), 32'(dif.ready), 32'd1);
      chk($sformatf("hold_lo%0d", i), dif.result_lo, 32'd3);
      chk($sformatf("hold_hi%0d", i), dif.result_hi, 32'd0);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_release", {30'd0, dif.busy, dif.ready}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back: start stays high through DONE; the next op must start from IDLE.
    apply(1'b0, 32'd9, 32'd3);
    wait_done(lat, lo, hi, sb);
    chk("b2b_first_lo", lo, 32'd3);
    @(posedge clk); #1;
    apply(1'b0, 32'd8, 32'd4);
    wait_done(lat, lo, hi, sb);
    chk("b2b_second_lo",  lo, 32'd2);
    chk("b2b_second_hi",  hi, 32'd0);
    chk("b2b_second_lat", 32'(lat), 32'(W + 1));
    chk("b2b_stallbusy",  32'(sb), 32'd0);
    @(posedge clk); #1;
    dif.start = 1'b0;
    @(posedge clk); #1;

    // Annul at cycle 10 of a CALC.
    apply(1'b0, 32'd100, 32'd7);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    dif.annul = 1'b1;
    dif.start = 1'b0;
    @(negedge clk);
    chk("annul_calc_stall", 32'(dif.stall_req), 32'd1);
    @(posedge clk); #1;
    dif.annul = 1'b0;
    @(negedge clk);
    chk("annul_busy",  32'(dif.busy), 32'd0);
    chk("annul_stall", 32'(dif.stall_req), 32'd0);
    chk("annul_lo",    dif.result_lo, 32'd2);
    chk("annul_hi",    dif.result_hi, 32'd0);
    rdy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dif.ready === 1'b1) rdy_cnt++;
    end
    chk("annul_no_ready", 32'(rdy_cnt), 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a CALC.
    apply(1'b0, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_lo",    dif.result_lo, '0);
    chk("rst_mid_hi",    dif.result_hi, '0);
    chk("rst_mid_ready", 32'(dif.ready), 32'd0);
    chk("rst_mid_busy",  32'(dif.busy),  32'd0);
    chk("rst_mid_stall", 32'(dif.stall_req), 32'd0);
    dif.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_after", {30'd0, dif.busy, dif.ready}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
